// File: rtl/count_monitor_if.sv
// count_monitor_if
//   Bundles the monitored count and the monitor's status outputs so the
//   counter side and the monitor side each see one connection.
//
//   Parameters
//     WIDTH  width of the monitored count D
//     CNT_W  width of the wrap and error counters
//
//   Signals
//     D          count value from the upstream counter
//     locked     monitor is locked onto the +1 sequence
//     wrap       one-cycle pulse on a locked max->0 step
//     seq_err    one-cycle pulse on an illegal step while locked
//     wraps      wrap counter (rolls over)
//     err_count  sequence error counter (saturates)
//
//   Modports
//     master  upstream/environment side: drives D, observes status
//     slave   the monitor: samples D, drives status
interface count_monitor_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0] D;
  logic             locked;
  logic             wrap;
  logic             seq_err;
  logic [CNT_W-1:0] wraps;
  logic [CNT_W-1:0] err_count;

  modport master (
    output D,
    input  locked, wrap, seq_err, wraps, err_count
  );

  modport slave (
    input  D,
    output locked, wrap, seq_err, wraps, err_count
  );
endinterface

// File: rtl/count_monitor.sv
// count_monitor
//   Watches a free-running WIDTH-bit counter sampled every clock. It locks
//   once SYNC_LEN consecutive +1 steps have been seen, then pulses wrap on
//   every max->0 step and pulses seq_err (dropping lock) on any step that
//   breaks the sequence. Wrap and error counts are kept for debug display.
//
//   Parameters
//     WIDTH     width of the monitored count
//     SYNC_LEN  consecutive legal steps needed to lock (1..255)
//     CNT_W     width of the wraps / err_count counters
//
//   Ports
//     clk    rising-edge clock shared with the upstream counter
//     reset  asynchronous, active-low reset
//     mon    count_monitor_if.slave: D in; locked, wrap, seq_err,
//            wraps, err_count out (all registered)
//
//   Build option
//     COUNT_MONITOR_STALL_EN  when defined, a hold step (D == previous D)
//                             is neutral in every state, so an upstream
//                             counter with a clock enable does not raise
//                             errors or lose lock. When undefined a hold
//                             is an illegal step.
module count_monitor #(
  parameter int WIDTH    = 4,
  parameter int SYNC_LEN = 2,
  parameter int CNT_W    = 8
) (
  input  logic            clk,
  input  logic            reset,
  count_monitor_if.slave  mon
);

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    LOCKED
  } state_t;

  localparam logic [8:0] SYNC_LEN9 = 9'(SYNC_LEN);

  state_t           state, state_n;
  logic [WIDTH-1:0] prev;
  logic [7:0]       run, run_n;
  logic             locked_q, locked_n;
  logic             wrap_q, wrap_n;
  logic             seq_err_q, seq_err_n;
  logic [CNT_W-1:0] wraps_q, wraps_n;
  logic [CNT_W-1:0] err_q, err_n;

  logic [WIDTH-1:0] expect_d;
  logic             step_legal;
  logic             step_wrap;
  logic             step_neutral;
  logic [8:0]       run_inc;

  // Step classification. The +1 is done in WIDTH bits so max->0 counts as
  // a legal step; a wrap is simply a legal step out of the all-ones value.
  assign expect_d   = prev + WIDTH'(1);
  assign step_legal = (mon.D == expect_d);
  assign step_wrap  = step_legal && (prev == '1);
  assign run_inc    = {1'b0, run} + 9'd1;

  // A neutral step leaves state, run and counters untouched. Only a hold
  // can be neutral, and only when stalls are tolerated.
`ifdef COUNT_MONITOR_STALL_EN
  assign step_neutral = (mon.D == prev);
`else
  assign step_neutral = 1'b0;
`endif

  // Next-state and next-output logic. Pulses default low so wrap and
  // seq_err last exactly one cycle; they come from mutually exclusive
  // branches of the LOCKED case and can never be high together.
  always_comb begin
    state_n   = state;
    run_n     = run;
    wrap_n    = 1'b0;
    seq_err_n = 1'b0;
    wraps_n   = wraps_q;
    err_n     = err_q;

    case (state)
      IDLE: begin
        state_n = SYNC;
        run_n   = 8'd0;
      end

      // Wrap steps here only advance run; lock is not yet trusted enough
      // to report wraps. Breaks restart the run silently.
      SYNC: begin
        if (step_legal) begin
          if (run_inc == SYNC_LEN9) begin
            state_n = LOCKED;
            run_n   = 8'd0;
          end else begin
            run_n = run_inc[7:0];
          end
        end else if (!step_neutral) begin
          run_n = 8'd0;
        end
      end

      LOCKED: begin
        if (step_legal) begin
          if (step_wrap) begin
            wrap_n  = 1'b1;
            wraps_n = wraps_q + CNT_W'(1);
          end
        end else if (!step_neutral) begin
          seq_err_n = 1'b1;
          if (err_q != '1) begin
            err_n = err_q + CNT_W'(1);
          end
          state_n = SYNC;
          run_n   = 8'd0;
        end
      end

      default: begin
        state_n = IDLE;
        run_n   = 8'd0;
      end
    endcase

    locked_n = (state_n == LOCKED);
  end

  // State and output registers. prev follows D on every edge once out of
  // reset so each edge judges exactly one (prev, D) step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      prev      <= '0;
      run       <= 8'd0;
      locked_q  <= 1'b0;
      wrap_q    <= 1'b0;
      seq_err_q <= 1'b0;
      wraps_q   <= '0;
      err_q     <= '0;
    end else begin
      state     <= state_n;
      prev      <= mon.D;
      run       <= run_n;
      locked_q  <= locked_n;
      wrap_q    <= wrap_n;
      seq_err_q <= seq_err_n;
      wraps_q   <= wraps_n;
      err_q     <= err_n;
    end
  end

  assign mon.locked    = locked_q;
  assign mon.wrap      = wrap_q;
  assign mon.seq_err   = seq_err_q;
  assign mon.wraps     = wraps_q;
  assign mon.err_count = err_q;

endmodule

// File: tb/tb_count_monitor.sv
// tb_count_monitor
//   Directed bench for count_monitor with WIDTH=4, SYNC_LEN=2, CNT_W=8.
//   Drives D as an upstream counter would (one value per clock), including
//   upstream resets, glitches, holds and a mid-pulse async reset, and checks
//   the registered outputs one time unit after each rising edge.
//   Honors COUNT_MONITOR_STALL_EN for the hold scenario.
module tb_count_monitor;

  localparam int WIDTH    = 4;
  localparam int SYNC_LEN = 2;
  localparam int CNT_W    = 8;

  logic clk;
  logic reset;

  int checks;
  int errors;

  logic [WIDTH-1:0] cur;
  logic [CNT_W-1:0] expWraps;
  int               expErr;
  int               guard;

  count_monitor_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  count_monitor #(
    .WIDTH(WIDTH),
    .SYNC_LEN(SYNC_LEN),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .mon(bus.slave)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Count one comparison and report it when observed and expected differ.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Present one D value and move just past the edge that samples it.
  task automatic applyStimulus(input logic [WIDTH-1:0] val);
    bus.D = val;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    expErr   = 0;
    expWraps = '0;
    reset    = 1'b0;
    bus.D    = '0;

    // Reset state
    #3;
    checkOutput("rst_locked",  32'(bus.locked),    0);
    checkOutput("rst_wrap",    32'(bus.wrap),      0);
    checkOutput("rst_seq_err", 32'(bus.seq_err),   0);
    checkOutput("rst_wraps",   32'(bus.wraps),     0);
    checkOutput("rst_err",     32'(bus.err_count), 0);
    #7;
    reset = 1'b1;

    // Count 0,1,2: lock rises at the edge sampling 2
    applyStimulus(4'd0);
    checkOutput("t1_locked_d0", 32'(bus.locked), 0);
    applyStimulus(4'd1);
    checkOutput("t1_locked_d1", 32'(bus.locked), 0);
    applyStimulus(4'd2);
    checkOutput("t1_locked_d2", 32'(bus.locked), 1);
    for (int v = 3; v < 16; v++) begin
      applyStimulus(4'(v));
      checkOutput("t1_nowrap", 32'(bus.wrap), 0);
    end
    applyStimulus(4'd0);
    checkOutput("t1_wrap1",   32'(bus.wrap),  1);
    checkOutput("t1_wraps1",  32'(bus.wraps), 1);
    applyStimulus(4'd1);
    checkOutput("t1_wrap_end", 32'(bus.wrap), 0);
    for (int v = 2; v < 16; v++) applyStimulus(4'(v));
    applyStimulus(4'd0);
    checkOutput("t1_wrap2",   32'(bus.wrap),    1);
    checkOutput("t1_wraps2",  32'(bus.wraps),   2);
    checkOutput("t1_seq_err", 32'(bus.seq_err), 0);

    // Upstream reset at 7: D held at 0 for two clocks
    for (int v = 1; v < 8; v++) applyStimulus(4'(v));
    applyStimulus(4'd0);
    expErr = 1;
    checkOutput("t2_seq_err",  32'(bus.seq_err),   1);
    checkOutput("t2_err",      32'(bus.err_count), 1);
    checkOutput("t2_locked",   32'(bus.locked),    0);
    checkOutput("t2_nowrap",   32'(bus.wrap),      0);
    applyStimulus(4'd0);
    checkOutput("t2_seq_err2", 32'(bus.seq_err),   0);
    checkOutput("t2_err2",     32'(bus.err_count), 1);
    applyStimulus(4'd1);
    checkOutput("t2_relock1",  32'(bus.locked),    0);
    applyStimulus(4'd2);
    checkOutput("t2_relock2",  32'(bus.locked),    1);
    checkOutput("t2_wraps",    32'(bus.wraps),     2);

    // Glitch: 9 where 5 is expected
    applyStimulus(4'd3);
    applyStimulus(4'd4);
    applyStimulus(4'd9);
    expErr = 2;
    checkOutput("t3_seq_err", 32'(bus.seq_err),   1);
    checkOutput("t3_err",     32'(bus.err_count), 2);
    checkOutput("t3_locked",  32'(bus.locked),    0);
    applyStimulus(4'd10);
    checkOutput("t3_relock1", 32'(bus.locked),    0);
    applyStimulus(4'd11);
    checkOutput("t3_relock2", 32'(bus.locked),    1);
    checkOutput("t3_wraps",   32'(bus.wraps),     2);

    // Hold D=4 for three clocks while locked
    for (int v = 12; v < 16; v++) applyStimulus(4'(v));
    applyStimulus(4'd0);
    expWraps = 8'd3;
    checkOutput("t4_wraps", 32'(bus.wraps), 3);
    for (int v = 1; v < 5; v++) applyStimulus(4'(v));
    applyStimulus(4'd4);
`ifdef COUNT_MONITOR_STALL_EN
    checkOutput("t4_hold_seq_err", 32'(bus.seq_err), 0);
    checkOutput("t4_hold_locked",  32'(bus.locked),  1);
`else
    expErr = 3;
    checkOutput("t4_hold_seq_err", 32'(bus.seq_err), 1);
    checkOutput("t4_hold_locked",  32'(bus.locked),  0);
`endif
    applyStimulus(4'd4);
    checkOutput("t4_hold2_seq_err", 32'(bus.seq_err), 0);
    applyStimulus(4'd4);
    applyStimulus(4'd5);
`ifdef COUNT_MONITOR_STALL_EN
    checkOutput("t4_resume_locked", 32'(bus.locked), 1);
`else
    checkOutput("t4_resume_locked", 32'(bus.locked), 0);
`endif
    applyStimulus(4'd6);
    checkOutput("t4_locked", 32'(bus.locked),    1);
    checkOutput("t4_err",    32'(bus.err_count), 32'(expErr));

    // 300 breaks, each followed by a two-step relock
    cur = 4'd6;
    for (int i = 0; i < 300; i++) begin
      cur = cur + 4'd3;
      applyStimulus(cur);
      checkOutput("t5_break_pulse", 32'(bus.seq_err), 1);
      expErr = (expErr == 255) ? 255 : expErr + 1;
      cur = cur + 4'd1;
      applyStimulus(cur);
      cur = cur + 4'd1;
      applyStimulus(cur);
    end
    checkOutput("t5_err_sat",   32'(bus.err_count), 255);
    checkOutput("t5_err_model", 32'(bus.err_count), 32'(expErr));
    checkOutput("t5_locked",    32'(bus.locked),    1);
    checkOutput("t5_wraps",     32'(bus.wraps),     32'(expWraps));

    // Count wraps until the counter reaches 255, then one more rolls to 0
    guard = 0;
    while (expWraps != 8'd255 && guard < 5000) begin
      cur = cur + 4'd1;
      applyStimulus(cur);
      if (cur == 4'd0) expWraps = expWraps + 8'd1;
      guard++;
    end
    checkOutput("t6_wraps_255", 32'(bus.wraps), 255);
    guard = 0;
    do begin
      cur = cur + 4'd1;
      applyStimulus(cur);
      guard++;
    end while (cur != 4'd0 && guard < 20);
    checkOutput("t6_wraps_roll", 32'(bus.wraps), 0);
    checkOutput("t6_wrap_pulse", 32'(bus.wrap),  1);

    // Async reset while wrap is high, between clock edges
    #2;
    reset = 1'b0;
    bus.D = 4'd1;
    #1;
    checkOutput("t7_wrap",    32'(bus.wrap),      0);
    checkOutput("t7_locked",  32'(bus.locked),    0);
    checkOutput("t7_wraps",   32'(bus.wraps),     0);
    checkOutput("t7_err",     32'(bus.err_count), 0);
    checkOutput("t7_seq_err", 32'(bus.seq_err),   0);
    #1;
    reset = 1'b1;
    applyStimulus(4'd1);
    checkOutput("t7_idle_edge", 32'(bus.locked), 0);
    applyStimulus(4'd2);
    checkOutput("t7_sync_edge", 32'(bus.locked), 0);
    applyStimulus(4'd3);
    checkOutput("t7_relock",    32'(bus.locked), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
